// File: rtl/aes_key_expand_if.sv
// Bus between the AES key expander and its user: start/key handshake,
// round-key read port and the shared 4-byte S-box lookup.
interface aes_key_expand_if;
  logic         init;
  logic [255:0] key;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  // Key expander side: consumes the request and the S-box result.
  modport slave (
    input  init, key, keylen, round, new_sboxw,
    output round_key, ready, sboxw
  );

  // User side: datapath that starts expansions, reads keys and owns the S-box.
  modport master (
    output init, key, keylen, round, new_sboxw,
    input  round_key, ready, sboxw
  );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128/AES-256 key expansion. Generates one 128-bit round key per cycle
// into a 15-entry key memory; SubWord comes from an external S-box that
// answers in the same cycle.
module aes_key_expand (
  input  logic             clk,
  input  logic             reset,
  aes_key_expand_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GENERATE = 2'd1,
    DONE     = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_ctr_q, round_ctr_d;   // index of the key being written
  logic [7:0]   rcon_q, rcon_d;
  logic [255:0] key_q, key_d;
  logic         keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic [127:0] key_mem_q [15];
  logic [127:0] key_mem_d [15];

  logic [127:0] round_key_s;
  logic [127:0] prev_key_s;
  logic [127:0] base_key_s;
  logic         sbox_phase_s;
  logic         use_rcon_s;
  logic [31:0]  temp_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [127:0] new_key_s;
  logic [3:0]   last_round_s;

  // Next round constant: multiply by x in GF(2^8).
  function automatic logic [7:0] rcon_next(input logic [7:0] r);
    rcon_next = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Key memory reads: datapath port plus the previous and second-previous
  // keys feeding the generator. Loop-based selects keep index 15 harmless.
  always_comb begin
    round_key_s = 128'h0;
    prev_key_s  = 128'h0;
    base_key_s  = 128'h0;
    for (int i = 0; i < 15; i++) begin
      if ({1'b0, bus.round} == 5'(i)) begin
        round_key_s = key_mem_q[i];
      end else begin
        round_key_s = round_key_s;
      end
      if ({1'b0, round_ctr_q} == 5'(i + 1)) begin
        prev_key_s = key_mem_q[i];
      end else begin
        prev_key_s = prev_key_s;
      end
      if ({1'b0, round_ctr_q} == 5'(i + 2)) begin
        base_key_s = key_mem_q[i];
      end else begin
        base_key_s = base_key_s;
      end
    end
  end

  // Round-key generator: S-box request, temp word and the chained XOR.
  always_comb begin
    sbox_phase_s = 1'b0;
    use_rcon_s   = 1'b1;
    temp_s       = 32'h0;
    last_round_s = keylen_q ? 4'd14 : 4'd10;
    new_key_s    = 128'h0;

    if (state_q == GENERATE) begin
      sbox_phase_s = keylen_q ? (round_ctr_q >= 4'd2) : (round_ctr_q >= 4'd1);
    end else begin
      sbox_phase_s = 1'b0;
    end

    // AES-256 odd keys use plain SubWord: no rotate, no round constant.
    use_rcon_s = ~keylen_q | ~round_ctr_q[0];

    if (use_rcon_s) begin
      temp_s = {bus.new_sboxw[23:0], bus.new_sboxw[31:24]} ^ {rcon_q, 24'h0};
    end else begin
      temp_s = bus.new_sboxw;
    end

    if (keylen_q) begin
      w0_s = base_key_s[127:96] ^ temp_s;
      w1_s = base_key_s[95:64]  ^ w0_s;
      w2_s = base_key_s[63:32]  ^ w1_s;
      w3_s = base_key_s[31:0]   ^ w2_s;
    end else begin
      w0_s = prev_key_s[127:96] ^ temp_s;
      w1_s = prev_key_s[95:64]  ^ w0_s;
      w2_s = prev_key_s[63:32]  ^ w1_s;
      w3_s = prev_key_s[31:0]   ^ w2_s;
    end

    if (round_ctr_q == 4'd0) begin
      new_key_s = key_q[255:128];
    end else if (keylen_q && (round_ctr_q == 4'd1)) begin
      new_key_s = key_q[127:0];
    end else begin
      new_key_s = {w0_s, w1_s, w2_s, w3_s};
    end
  end

  // Control FSM next state, key memory write and register updates.
  always_comb begin
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    rcon_d      = rcon_q;
    key_d       = key_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    key_mem_d   = key_mem_q;

    case (state_q)
      IDLE: begin
        if (bus.init) begin
          key_d       = bus.key;
          keylen_d    = bus.keylen;
          ready_d     = 1'b0;
          round_ctr_d = 4'd0;
          rcon_d      = 8'h01;
          state_d     = GENERATE;
        end else begin
          state_d = IDLE;
        end
      end
      GENERATE: begin
        for (int i = 0; i < 15; i++) begin
          if ({1'b0, round_ctr_q} == 5'(i)) begin
            key_mem_d[i] = new_key_s;
          end else begin
            key_mem_d[i] = key_mem_q[i];
          end
        end
        // The round constant only moves on once it has been consumed.
        if (sbox_phase_s && use_rcon_s) begin
          rcon_d = rcon_next(rcon_q);
        end else begin
          rcon_d = rcon_q;
        end
        if (round_ctr_q == last_round_s) begin
          state_d = DONE;
        end else begin
          round_ctr_d = round_ctr_q + 4'd1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset empties the key memory so no partial key survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      round_ctr_q <= 4'd0;
      rcon_q      <= 8'h01;
      key_q       <= 256'h0;
      keylen_q    <= 1'b0;
      ready_q     <= 1'b1;
      for (int i = 0; i < 15; i++) begin
        key_mem_q[i] <= 128'h0;
      end
    end else begin
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      rcon_q      <= rcon_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
      for (int i = 0; i < 15; i++) begin
        key_mem_q[i] <= key_mem_d[i];
      end
    end
  end

  assign bus.round_key = round_key_s;
  assign bus.ready     = ready_q;
  assign bus.sboxw     = sbox_phase_s ? prev_key_s[31:0] : 32'h0;

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset; one clock, reset asynchronous and active-high.
REQ-003 SHALL have port init, input, 1, single-cycle pulse that starts key expansion.
REQ-004 SHALL have port key, input, 256, cipher key; AES-128 uses key[255:128] only.
REQ-005 SHALL have port keylen, input, 1, 0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds).
REQ-006 SHALL have port round, input, 4, round-key index requested by the encipher/decipher datapath.
REQ-007 SHALL have port round_key, output, 128, combinational read of key_mem[round].
REQ-008 SHALL have port ready, output, 1, high when idle and key memory is valid.
REQ-009 SHALL have port sboxw, output, 32, word sent to shared external 4-byte S-box.
REQ-010 SHALL have port new_sboxw, input, 32, S-box result, same cycle.

Function
REQ-011 SHALL hold a 15 x 128-bit key memory, a 4-bit round counter, an 8-bit rcon register, key and keylen latched at init, and an FSM IDLE -> GENERATE -> DONE -> IDLE.
REQ-012 SHALL, in IDLE with init=1 at edge E0: latch key/keylen, clear ready, set round counter 0, set rcon 8'h01, enter GENERATE.
REQ-013 SHALL write exactly one round key per cycle in GENERATE: key k written at edge E(k+1), k = 0..N (N=10 or 14).
REQ-014 SHALL write key 0 = key[255:128]; in AES-256 key 1 = key[127:0].
REQ-015 SHALL drive sboxw = word [31:0] of key k-1 while generating key k (k>=1 AES-128, k>=2 AES-256); 32'h0 otherwise.
REQ-016 SHALL, for AES-128 key k>=1: t = RotWord(new_sboxw) ^ {rcon,24'h0}, RotWord = {x[23:0],x[31:24]}; w0 = p0^t, w1 = p1^w0, w2 = p2^w1, w3 = p3^w2, p = key k-1 (p0 = bits 127:96).
REQ-017 SHALL, for AES-256 key k>=2: base = key k-2; even k: t = RotWord(new_sboxw) ^ {rcon,24'h0}; odd k: t = new_sboxw (no rotate, no rcon); words chained as REQ-016 on base.
REQ-018 SHALL advance rcon only after a use: rcon <= {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00); sequence 01,02,...,80,1b,36.
REQ-019 SHALL, after writing key N, enter DONE for one cycle, then IDLE; ready=1 visible after edge E(N+2) (E12 for AES-128, E16 for AES-256).
REQ-020 SHALL ignore init while in GENERATE or DONE; no restart, latched key unchanged.
REQ-021 SHALL accept init in the first IDLE cycle after DONE.
REQ-022 SHALL return 128'h0 on round_key for round = 15; AES-128 indices 11..14 return stale memory contents, not required by datapath.
REQ-023 SHALL keep round_key valid and stable while ready=1 and no init.

Reset
REQ-024 SHALL, on reset=1, asynchronously clear: FSM -> IDLE, round counter 0, rcon 8'h01, all key_mem entries 128'h0, ready -> 1.
REQ-025 SHALL abort an expansion in progress on reset; no partial key remains; next init restarts from key 0.

Verification
REQ-026 AES-128 key 000102030405060708090a0b0c0d0e0f (in key[255:128]), init -> ready after 12 edges; round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-027 AES-256 key 000102...1e1f, init -> ready after 16 edges; round 2 = a573c29fa176c498a97fce93a572c09c, round 14 = 24fc79ccbf0979e9371ac23c6d68de36.
REQ-028 init pulsed again at cycle 5 of AES-128 expansion -> ignored; ready timing and all 11 keys unchanged.
REQ-029 reset asserted at cycle 6 of AES-256 expansion -> ready=1, round_key=0 for all rounds; new AES-128 init then yields REQ-026 keys.
REQ-030 Back-to-back: AES-256 expansion, init in first IDLE cycle with AES-128 key -> round 10 = 13111d7f...; connected to aes_encipher_block, plaintext 00112233445566778899aabbccddeeff encrypts to 69c4e0d86a7b0430d8cdb78070b4c55a.
